// File: rtl/timer_mc_pkg.sv
//==============================================================================
// Module  : timer_mc_pkg
// Purpose : Shared definitions for the multi-channel machine timer.
//           - Register offsets (decoded on addr[9:0]).
//           - CTRL bit positions.
//           - Register-select encoding used by the bus decoder.
//           - byte_merge(): applies byte enables to a 32-bit register write.
// Ports   : none (package)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package timer_mc_pkg;

  // Register offsets within the 1 KiB timer window.
  localparam logic [9:0] MTIME_LO = 10'h000;
  localparam logic [9:0] MTIME_HI = 10'h004;
  localparam logic [9:0] PRESC    = 10'h008;
  localparam logic [9:0] CTRL     = 10'h00C;

  // Comparator channel i occupies CMP_BASE + CMP_STRIDE*i (LO) and +4 (HI).
  localparam logic [9:0]  CMP_BASE   = 10'h100;
  localparam int unsigned CMP_STRIDE = 8;

  // CTRL register fields.
  localparam int unsigned CTRL_EN_BIT = 0;

  // Which register a bus access targets; SEL_NONE flags an access error.
  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,
    SEL_MTIME_LO = 3'd1,
    SEL_MTIME_HI = 3'd2,
    SEL_PRESC    = 3'd3,
    SEL_CTRL     = 3'd4,
    SEL_CMP_LO   = 3'd5,
    SEL_CMP_HI   = 3'd6
  } reg_sel_e;

  // Bytes whose enable is clear keep the old value.
  function automatic logic [31:0] byte_merge(input logic [31:0] wdata,
                                             input logic [3:0]  be,
                                             input logic [31:0] old);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_mc_cmp.sv
//==============================================================================
// Module  : timer_mc_cmp
// Purpose : One timer comparator channel: a 64-bit compare register written
//           as two byte-enabled 32-bit halves, an unsigned compare against the
//           shared mtime, and a sticky interrupt flop that is cleared only by a
//           write to either half of this channel's compare register.
// Ports   : clk_i, rst_ni      - clock, asynchronous active-low reset
//           wr_lo_i, wr_hi_i   - accepted write to CMP_LO / CMP_HI
//           wdata_i, be_i      - bus write data and byte enables
//           mtime_i            - registered mtime value
//           cmp_o              - compare register, for bus readback
//           intr_o             - sticky interrupt (registered)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_mc_cmp
  import timer_mc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  input  logic [63:0] mtime_i,
  output logic [63:0] cmp_o,
  output logic        intr_o
);

  logic [63:0] r_cmp;
  logic        r_irq;
  logic        w_cmp_wr;
  logic        w_hit;
  logic        w_irq_d;

  assign w_cmp_wr = wr_lo_i | wr_hi_i;
  assign w_hit    = (mtime_i >= r_cmp);

  // A compare write in the same cycle as a hit clears the flag; the hit is
  // re-evaluated next cycle against the newly written compare value.
  assign w_irq_d = (r_irq | w_hit) & ~w_cmp_wr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // All-ones compare value keeps the channel quiet out of reset.
      r_cmp <= '1;
      r_irq <= 1'b0;
    end else begin
      if (wr_lo_i) begin
        r_cmp[31:0] <= byte_merge(wdata_i, be_i, r_cmp[31:0]);
      end
      if (wr_hi_i) begin
        r_cmp[63:32] <= byte_merge(wdata_i, be_i, r_cmp[63:32]);
      end
      r_irq <= w_irq_d;
    end
  end

  assign cmp_o  = r_cmp;
  assign intr_o = r_irq;

endmodule

`default_nettype wire

// File: rtl/timer_mc.sv
//==============================================================================
// Module  : timer_mc
// Purpose : Multi-channel prescaled RISC-V machine timer. One shared 64-bit
//           mtime counter advanced by a programmable prescaler, and NumCmp
//           independent mtimecmp channels, each with a sticky interrupt line.
//           Single-cycle req/rvalid peripheral bus, read latency 1.
// Ports   : clk_i, rst_ni        - clock, asynchronous active-low reset
//           timer_req_i          - bus request (one cycle per access)
//           timer_addr_i         - byte address, bits [9:0] decoded
//           timer_we_i           - write enable
//           timer_be_i           - byte enables (writes only)
//           timer_wdata_i        - write data
//           timer_rvalid_o       - response valid, cycle after request
//           timer_rdata_o        - read data (pre-write value on writes)
//           timer_err_o          - access to an unmapped address
//           timer_intr_o         - per-channel timer interrupts
// Config  : TIMER_MC_SNAPSHOT_EN - when defined, a read of MTIME_LO captures
//           mtime[63:32] into a shadow that MTIME_HI then returns, giving a
//           tear-free LO-then-HI 64-bit read.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_mc
  import timer_mc_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned NumCmp       = 4,
  parameter int unsigned PrescWidth   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    timer_req_i,
  input  logic [AddressWidth-1:0] timer_addr_i,
  input  logic                    timer_we_i,
  input  logic [DataWidth/8-1:0]  timer_be_i,
  input  logic [DataWidth-1:0]    timer_wdata_i,
  output logic                    timer_rvalid_o,
  output logic [DataWidth-1:0]    timer_rdata_o,
  output logic                    timer_err_o,
  output logic [NumCmp-1:0]       timer_intr_o
);

  // First byte address past the last implemented comparator channel.
  localparam logic [9:0] c_cmp_end = CMP_BASE + 10'(NumCmp * CMP_STRIDE);

  //--------------------------------------------------------------------------
  // Bus decode
  //--------------------------------------------------------------------------
  logic [9:0]  w_addr;
  reg_sel_e    w_sel;
  logic        w_err;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_wr_presc;
  logic        w_wr_ctrl;
  logic        w_unused_addr;

  assign w_addr = timer_addr_i[9:0];

  // Address bits above the decoded window are ignored.
  assign w_unused_addr = ^timer_addr_i[AddressWidth-1:10];

  always_comb begin
    w_sel = SEL_NONE;
    if (w_addr == MTIME_LO) begin
      w_sel = SEL_MTIME_LO;
    end else if (w_addr == MTIME_HI) begin
      w_sel = SEL_MTIME_HI;
    end else if (w_addr == PRESC) begin
      w_sel = SEL_PRESC;
    end else if (w_addr == CTRL) begin
      w_sel = SEL_CTRL;
    end else if ((w_addr >= CMP_BASE) && (w_addr < c_cmp_end) &&
                 (w_addr[1:0] == 2'b00)) begin
      // Within the comparator window, bit 2 picks the half.
      w_sel = w_addr[2] ? SEL_CMP_HI : SEL_CMP_LO;
    end
  end

  assign w_err = (w_sel == SEL_NONE);
  assign w_wr  = timer_req_i & timer_we_i;
  assign w_rd  = timer_req_i & ~timer_we_i;

  assign w_wr_mtime_lo = w_wr & (w_sel == SEL_MTIME_LO);
  assign w_wr_mtime_hi = w_wr & (w_sel == SEL_MTIME_HI);
  assign w_wr_presc    = w_wr & (w_sel == SEL_PRESC);
  assign w_wr_ctrl     = w_wr & (w_sel == SEL_CTRL);

  //--------------------------------------------------------------------------
  // Configuration registers: PRESC and CTRL
  //--------------------------------------------------------------------------
  logic [PrescWidth-1:0] r_presc;
  logic                  r_en;
  logic [31:0]           w_presc_ext;

  assign w_presc_ext = 32'(r_presc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_presc <= '0;
      r_en    <= 1'b1;
    end else begin
      if (w_wr_presc) begin
        r_presc <= PrescWidth'(byte_merge(timer_wdata_i, timer_be_i, w_presc_ext));
      end
      if (w_wr_ctrl && timer_be_i[CTRL_EN_BIT/8]) begin
        r_en <= timer_wdata_i[CTRL_EN_BIT];
      end
    end
  end

  //--------------------------------------------------------------------------
  // Prescaler
  //--------------------------------------------------------------------------
  logic [PrescWidth-1:0] r_presc_cnt;
  logic                  w_tick;

  assign w_tick = r_en & (r_presc_cnt == r_presc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_presc_cnt <= '0;
    end else if (w_wr_presc || w_wr_ctrl) begin
      // Reprogramming restarts the prescaler phase.
      r_presc_cnt <= '0;
    end else if (r_en) begin
      r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PrescWidth'(1);
    end
  end

  //--------------------------------------------------------------------------
  // mtime
  //--------------------------------------------------------------------------
  logic [63:0] r_mtime;
  logic [63:0] w_mtime_inc;

  // Wraps from all-ones to zero naturally.
  assign w_mtime_inc = r_mtime + 64'd1;

  // A half-write replaces only that half; the other half follows the
  // incremented value on a tick and holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtime <= '0;
    end else if (w_wr_mtime_lo) begin
      r_mtime[31:0]  <= byte_merge(timer_wdata_i, timer_be_i, r_mtime[31:0]);
      r_mtime[63:32] <= w_tick ? w_mtime_inc[63:32] : r_mtime[63:32];
    end else if (w_wr_mtime_hi) begin
      r_mtime[63:32] <= byte_merge(timer_wdata_i, timer_be_i, r_mtime[63:32]);
      r_mtime[31:0]  <= w_tick ? w_mtime_inc[31:0] : r_mtime[31:0];
    end else if (w_tick) begin
      r_mtime <= w_mtime_inc;
    end
  end

  //--------------------------------------------------------------------------
  // MTIME_HI readback source
  //--------------------------------------------------------------------------
  logic [31:0] w_mtime_hi_rd;

`ifdef TIMER_MC_SNAPSHOT_EN
  logic [31:0] r_mtime_shadow;

  // Reading LO freezes the matching upper half so a following HI read
  // cannot observe a carry that happened in between.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtime_shadow <= '0;
    end else if (w_rd && (w_sel == SEL_MTIME_LO)) begin
      r_mtime_shadow <= r_mtime[63:32];
    end
  end

  assign w_mtime_hi_rd = r_mtime_shadow;
`else
  assign w_mtime_hi_rd = r_mtime[63:32];
`endif

  //--------------------------------------------------------------------------
  // Comparator channels
  //--------------------------------------------------------------------------
  logic [63:0] w_cmp_q [NumCmp];

  for (genvar i = 0; i < NumCmp; i++) begin : g_cmp
    logic w_ch_sel;

    // Channel index lives in addr[7:3] because CMP_BASE is 256-aligned.
    assign w_ch_sel = (w_addr[7:3] == 5'(i));

    timer_mc_cmp u_cmp (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wr_lo_i (w_wr && (w_sel == SEL_CMP_LO) && w_ch_sel),
      .wr_hi_i (w_wr && (w_sel == SEL_CMP_HI) && w_ch_sel),
      .wdata_i (timer_wdata_i),
      .be_i    (timer_be_i),
      .mtime_i (r_mtime),
      .cmp_o   (w_cmp_q[i]),
      .intr_o  (timer_intr_o[i])
    );
  end

  //--------------------------------------------------------------------------
  // Read mux
  //--------------------------------------------------------------------------
  logic [63:0] w_cmp_rd;
  logic [31:0] w_rdata;

  always_comb begin
    w_cmp_rd = '0;
    for (int i = 0; i < NumCmp; i++) begin
      if (w_addr[7:3] == 5'(i)) begin
        w_cmp_rd = w_cmp_q[i];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_MTIME_LO: w_rdata = r_mtime[31:0];
      SEL_MTIME_HI: w_rdata = w_mtime_hi_rd;
      SEL_PRESC:    w_rdata = w_presc_ext;
      SEL_CTRL:     w_rdata[CTRL_EN_BIT] = r_en;
      SEL_CMP_LO:   w_rdata = w_cmp_rd[31:0];
      SEL_CMP_HI:   w_rdata = w_cmp_rd[63:32];
      default:      w_rdata = '0;
    endcase
  end

  //--------------------------------------------------------------------------
  // Response registers
  //--------------------------------------------------------------------------
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  // rdata/err only update on a request so they hold between accesses.
  // Writes return the value the register had before the write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= timer_req_i;
      if (timer_req_i) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
    end
  end

  assign timer_rvalid_o = r_rvalid;
  assign timer_rdata_o  = r_rdata;
  assign timer_err_o    = r_err;

endmodule

`default_nettype wire

// File: doc/timer_mc.md
# timer_mc

Multi-channel, prescaled RISC-V machine timer and the parametrised successor of the single-compare mtime timer. It holds one shared 64-bit `mtime` counter, advanced by a programmable prescaler, and `NumCmp` independent 64-bit `mtimecmp` comparators. Each comparator drives its own sticky interrupt line, one per hart or per timer client. It sits on the same single-cycle req/rvalid peripheral bus as the existing timer.

## Interface
- `DataWidth`, 32, bus data width; only 32 is supported.
- `AddressWidth`, 32, bus address width; bits [9:0] are decoded.
- `NumCmp`, 4, number of comparator channels, 1..16.
- `PrescWidth`, 16, width of the prescaler reload register, 1..32.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset: asynchronous, active-low. Clock is `clk_i`.
- `timer_req_i`  in  1  bus request, one cycle per access.
- `timer_addr_i`  in  AddressWidth  byte address.
- `timer_we_i`  in  1  write enable.
- `timer_be_i`  in  DataWidth/8  byte enables; applied to writes only.
- `timer_wdata_i`  in  DataWidth  write data.
- `timer_rvalid_o`  out  1  response valid; reset 0.
- `timer_rdata_o`  out  DataWidth  read data; reset 0.
- `timer_err_o`  out  1  access error; reset 0.
- `timer_intr_o`  out  NumCmp  per-channel timer interrupt; reset all 0.

## Operation
- Register map, on addr[9:0]:
  - 0x000 MTIME_LO; 0x004 MTIME_HI.
  - 0x008 PRESC: [PrescWidth-1:0], reset 0.
  - 0x00C CTRL: bit0 EN, reset 1; other bits read 0.
  - 0x100+8*i CMP_LO[i]; 0x104+8*i CMP_HI[i], for i < NumCmp. CMP reset value is all-ones, so no interrupt fires out of reset.
- Any other address, including channels at or above NumCmp, sets err: writes are dropped and reads return 0.
- Byte-enabled writes: bytes whose enable is clear keep their current value.
- Prescaler: `presc_cnt` counts from 0 while EN=1. When `presc_cnt == PRESC`, the cycle is a tick: `presc_cnt` returns to 0 and `mtime` increments by 1.
  - PRESC=0 gives a tick every cycle.
  - EN=0 holds both `presc_cnt` and `mtime`.
  - A write to PRESC or CTRL clears `presc_cnt`.
- `mtime` write: the written half takes the bus value. The other half takes its incremented value if this cycle is a tick, otherwise it holds. There is no carry into or out of the written half.
- `mtime` wraps from 2^64-1 to 0.
- Interrupt for channel i: `irq_d[i] = (irq_q[i] | (mtime_q >= cmp_q[i])) & ~cmp_wr[i]`. `cmp_wr[i]` is a write to either half of channel i.
  - The interrupt is sticky and is cleared only by writing that channel's CMP.
  - Unsigned 64-bit compare on registered values.
- When a CMP write and the compare condition occur in the same cycle, the clear wins. The next cycle re-evaluates against the new compare value.

## Timing
- Read latency is 1: `rvalid` is high the cycle after `req`. `rdata` and `err` are registered only when `req` is high and hold otherwise.
- Writes also produce `rvalid`, with rdata equal to the pre-write value.
- A register write takes effect at the request edge and is visible to a read in the next request.
- Interrupt latency: `intr_o[i]` rises 1 cycle after `mtime_q` first reaches `cmp_q[i]`. It falls 1 cycle after a CMP write is accepted.
- Back-to-back requests are allowed every cycle; there is no stall and no ready signal.
- Reset mid-operation: all state returns to reset values asynchronously, and `rvalid` drops immediately.

## Configuration
- `TIMER_MC_SNAPSHOT_EN`:
  - Defined: a read of MTIME_LO also captures `mtime_q[63:32]` into a shadow register, and a read of MTIME_HI returns that shadow. This gives a tear-free 64-bit read as LO then HI. The shadow resets to 0.
  - Undefined: MTIME_HI returns the live `mtime_q[63:32]`. The shadow register is not built.

## Structure
- Package `timer_mc_pkg`:
  - Register offset localparams (MTIME_LO, MTIME_HI, PRESC, CTRL, CMP_BASE=0x100, CMP_STRIDE=8).
  - CTRL bit index `CTRL_EN_BIT`.
  - A byte-merge function (wdata, be, old).
- Sub-module `timer_mc_cmp`, instantiated NumCmp times. It contains one 64-bit CMP register, the byte-merge writes, the compare logic and the sticky interrupt flop, and exposes `cmp_q` for readback.
- The top level owns bus decode, the prescaler, `mtime`, the optional snapshot and the response registers.

## Test plan
- Reset, then read MTIME_LO twice with 3 idle cycles between reads, PRESC=0 → values differ by 4. CTRL reads 1, CMP_LO[0] reads 0xFFFFFFFF, all interrupts are 0.
- Write PRESC=3 → MTIME_LO advances once every 4 cycles. Write CTRL=0 → `mtime` is frozen across 10 cycles.
- Write MTIME={0,0xFFFFFFFE}, CMP[2]={1,0x00000002} → `intr_o[2]` rises 1 cycle after `mtime` reaches 0x1_00000002 while other channels stay 0. Then write CMP_HI[2]=0xFFFFFFFF → `intr_o[2]` falls the next cycle.
- Write CMP_LO[1] with be=4'b0001 and data 0xAABBCCDD → CMP_LO[1] reads 0xFFFFFFDD.
- Read address 0x100+8*NumCmp and address 0x010 → `err` is 1, rdata is 0, `rvalid` is 1. A write to either address changes no register.
- With `TIMER_MC_SNAPSHOT_EN` defined: set MTIME to 0x0_FFFFFFFF, read LO, wait 5 cycles, read HI → HI returns 0, not 1.
